// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: multi-cycle data memory access with upstream stall and M/WB register
module mem_stage #(
    parameter int MEM_WORDS   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] EX_M_result,
    input  logic [31:0] EX_M_write_data,
    input  logic [4:0]  EX_M_rd,
    input  logic        EX_M_memread,
    input  logic        EX_M_memwrite,
    input  logic        EX_M_memtoreg,
    input  logic        EX_M_regwrite,
    output logic        stall,
    output logic [31:0] M_WB_read_data,
    output logic [31:0] M_WB_result,
    output logic [4:0]  M_WB_rd,
    output logic        M_WB_memtoreg,
    output logic        M_WB_regwrite
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LATENCY - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_next_cnt;
    logic [31:0]     r_mem [MEM_WORDS];
    logic [AW-1:0]   w_index;
    logic            w_access;
    logic            w_final;
    logic            w_commit;

    // Low address bits select the byte in a word; high bits wrap away.
    assign w_index  = EX_M_result[AW+1:2];
    assign w_access = EX_M_memread | EX_M_memwrite;
    assign stall    = w_access & ~w_final;

    // Next-state logic: decide when the access reaches its final cycle and commits.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_final      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_access) begin
                    w_commit = 1'b1;
                end else if (MEM_LATENCY == 1) begin
                    w_final  = 1'b1;
                    w_commit = 1'b1;
                end else begin
                    w_next_state = S_BUSY;
                    w_next_cnt   = CW'(1);
                end
            end
            S_BUSY: begin
                if (r_cnt == LAST_CNT) begin
                    w_final      = 1'b1;
                    w_commit     = 1'b1;
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // State and cycle counter; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Data memory write, only at the committing edge of a store; contents are never reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_access && EX_M_memwrite) begin
            r_mem[w_index] <= EX_M_write_data;
        end
    end

    // M/WB register: full update on commit, bubble (no write-back) on non-final access cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_WB_read_data <= '0;
            M_WB_result    <= '0;
            M_WB_rd        <= '0;
            M_WB_memtoreg  <= 1'b0;
            M_WB_regwrite  <= 1'b0;
        end else if (w_commit) begin
            M_WB_read_data <= (w_access && EX_M_memread) ? r_mem[w_index] : 32'd0;
            M_WB_result    <= EX_M_result;
            M_WB_rd        <= EX_M_rd;
            M_WB_memtoreg  <= EX_M_memtoreg;
            M_WB_regwrite  <= EX_M_regwrite;
        end else begin
            M_WB_memtoreg  <= 1'b0;
            M_WB_regwrite  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage at latencies 1, 2 and 3
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] in_res [3];
    logic [31:0] in_wd  [3];
    logic [4:0]  in_rd  [3];
    logic        in_mr  [3];
    logic        in_mw  [3];
    logic        in_mtr [3];
    logic        in_rw  [3];
    logic        o_stall [3];
    logic [31:0] o_rdata [3];
    logic [31:0] o_res   [3];
    logic [4:0]  o_rd    [3];
    logic        o_mtr   [3];
    logic        o_rw    [3];

    mem_stage #(.MEM_WORDS(256), .MEM_LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .EX_M_result(in_res[0]), .EX_M_write_data(in_wd[0]), .EX_M_rd(in_rd[0]),
        .EX_M_memread(in_mr[0]), .EX_M_memwrite(in_mw[0]),
        .EX_M_memtoreg(in_mtr[0]), .EX_M_regwrite(in_rw[0]),
        .stall(o_stall[0]), .M_WB_read_data(o_rdata[0]), .M_WB_result(o_res[0]),
        .M_WB_rd(o_rd[0]), .M_WB_memtoreg(o_mtr[0]), .M_WB_regwrite(o_rw[0])
    );
    mem_stage #(.MEM_WORDS(256), .MEM_LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n),
        .EX_M_result(in_res[1]), .EX_M_write_data(in_wd[1]), .EX_M_rd(in_rd[1]),
        .EX_M_memread(in_mr[1]), .EX_M_memwrite(in_mw[1]),
        .EX_M_memtoreg(in_mtr[1]), .EX_M_regwrite(in_rw[1]),
        .stall(o_stall[1]), .M_WB_read_data(o_rdata[1]), .M_WB_result(o_res[1]),
        .M_WB_rd(o_rd[1]), .M_WB_memtoreg(o_mtr[1]), .M_WB_regwrite(o_rw[1])
    );
    mem_stage #(.MEM_WORDS(256), .MEM_LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n),
        .EX_M_result(in_res[2]), .EX_M_write_data(in_wd[2]), .EX_M_rd(in_rd[2]),
        .EX_M_memread(in_mr[2]), .EX_M_memwrite(in_mw[2]),
        .EX_M_memtoreg(in_mtr[2]), .EX_M_regwrite(in_rw[2]),
        .stall(o_stall[2]), .M_WB_read_data(o_rdata[2]), .M_WB_result(o_res[2]),
        .M_WB_rd(o_rd[2]), .M_WB_memtoreg(o_mtr[2]), .M_WB_regwrite(o_rw[2])
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one word array per instance plus a written-yet flag.
    logic [31:0] mdl   [3][256];
    bit          known [3][256];
    logic [7:0]  pat;
    logic [31:0] last_rd;

    typedef struct {
        logic        mr, mw, mtr, rw;
        logic [31:0] addr, wd;
        logic [4:0]  rd;
        logic [31:0] exp_rd;
        bit          chk;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic mr, input logic mw, input logic mtr,
                          input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd);
        in_mr[sel] = mr;  in_mw[sel] = mw;  in_mtr[sel] = mtr; in_rw[sel] = rw;
        in_res[sel] = addr; in_wd[sel] = wd; in_rd[sel] = rd;
    endtask

    task automatic clear_in(input int sel);
        set_in(sel, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    endtask

    // One instruction through instance sel; expectations come from the word-array model.
    task automatic do_op(input int sel, input logic mr, input logic mw, input logic mtr,
                         input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd);
        int          idx;
        int          nst;
        logic [31:0] exp_rd;
        bit          chk_rd;
        idx = int'((addr >> 2) % 256);
        if (!(mr || mw)) begin
            exp_rd = 32'd0; chk_rd = 1'b1;
        end else if (mr) begin
            exp_rd = mdl[sel][idx]; chk_rd = known[sel][idx];
        end else begin
            exp_rd = 32'd0; chk_rd = 1'b0;
        end
        @(negedge clk);
        set_in(sel, mr, mw, mtr, rw, addr, wd, rd);
        #1;
        nst = 0;
        while (o_stall[sel] && nst < 10) begin
            pat = {pat[6:0], 1'b1};
            nst++;
            @(posedge clk); #1;
            check("bubble_regwrite", 32'(o_rw[sel]), 32'd0);
            check("bubble_memtoreg", 32'(o_mtr[sel]), 32'd0);
        end
        pat = {pat[6:0], 1'b0};
        check("stall_cycles", 32'(nst), ((mr || mw) ? 32'(sel) : 32'd0));
        @(posedge clk); #1;
        check("wb_result", o_res[sel], addr);
        check("wb_rd", 32'(o_rd[sel]), 32'(rd));
        check("wb_regwrite", 32'(o_rw[sel]), 32'(rw));
        check("wb_memtoreg", 32'(o_mtr[sel]), 32'(mtr));
        if (chk_rd) check("wb_read_data", o_rdata[sel], exp_rd);
        last_rd = o_rdata[sel];
        if (mw) begin
            mdl[sel][idx]   = wd;
            known[sel][idx] = 1'b1;
        end
        clear_in(sel);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            clear_in(s);
            for (int w = 0; w < 256; w++) known[s][w] = 1'b0;
        end
        pat = '0;
        last_rd = '0;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd3, 32'd0,         1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'd0,        5'd4, 32'hDEAD_BEEF, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'd0,        5'd7, 32'd0,         1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0403, 32'hA5A5_A5A5, 5'd1, 32'd0,        1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'd0,        5'd2, 32'hA5A5_A5A5, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0001, 5'd0, 32'd0,        1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0002, 5'd9, 32'h0000_0001, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'd0,        5'd9, 32'h0000_0002, 1'b1};

        // Reset held across clocks, then released.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            check("rst_stall", 32'(o_stall[s]), 32'd0);
            check("rst_read_data", o_rdata[s], 32'd0);
            check("rst_result", o_res[s], 32'd0);
            check("rst_rd", 32'(o_rd[s]), 32'd0);
            check("rst_memtoreg", 32'(o_mtr[s]), 32'd0);
            check("rst_regwrite", 32'(o_rw[s]), 32'd0);
        end

        // Directed vectors on every latency.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                pat = '0;
                do_op(s, tbl[i].mr, tbl[i].mw, tbl[i].mtr, tbl[i].rw, tbl[i].addr, tbl[i].wd, tbl[i].rd);
                if (tbl[i].chk) check("tbl_read_data", last_rd, tbl[i].exp_rd);
                if (s == 2 && i == 0) check("store_stall_pattern_l3", 32'(pat[2:0]), 32'(3'b110));
            end
        end

        // Back-to-back store then load at latency 2.
        pat = '0;
        do_op(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h5, 5'd0);
        do_op(1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0, 5'd5);
        check("b2b_stall_pattern", 32'(pat[3:0]), 32'(4'b1010));
        check("b2b_read_data", last_rd, 32'h5);

        // Asynchronous reset between edges clears M/WB at once.
        do_op(2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'd0, 5'd7);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_result", o_res[2], 32'd0);
        check("async_rst_rd", 32'(o_rd[2]), 32'd0);
        check("async_rst_regwrite", 32'(o_rw[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the second cycle of a latency-3 store must drop the write.
        do_op(2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1111_1111, 5'd0);
        @(negedge clk);
        set_in(2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h2222_2222, 5'd0);
        @(posedge clk);
        #2;
        check("midstore_stall", 32'(o_stall[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midstore_rst_regwrite", 32'(o_rw[2]), 32'd0);
        clear_in(2);
        #1;
        check("midstore_rst_stall", 32'(o_stall[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'd0, 5'd6);
        check("midstore_read_back", last_rd, 32'h1111_1111);

        // Randomized traffic against the model.
        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < 60; n++) begin
                int          kind;
                logic [31:0] a;
                kind = int'($urandom_range(0, 3));
                a = ($urandom() & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
                do_op(s, kind[0] & kind[1] | (kind == 1), (kind >= 2),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      a, $urandom(), 5'($urandom_range(0, 31)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
